bc_int_ctrl: RTL and testbench

Interrupt and I/O controller for the Basic Computer. It owns the IEN, R, FGI and FGO flip-flops and the INPR/OUTR character buffers, executes the six register-reference I/O instructions (INP, OUT, SKI, SKO, ION, IOF), and drives the three-cycle interrupt cycle (RT0–RT2) alongside the main CONTROLLER. It sits between the external character devices and the DATA_PATH/CONTROLLER pair; the CONTROLLER suppresses instruction fetch whenever `int_cycle` is high.

---
 rtl/bc_pkg.sv | 45 ++++
 rtl/bc_int_ctrl_if.sv | 35 +++
 rtl/bc_int_ctrl.sv | 129 ++++++++++++
 tb/tb_bc_int_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared constants for the Basic Computer interrupt and I/O controller:
// IR I/O bit positions, sequence-counter states and default widths.
package bc_pkg;

    localparam int IO_WIDTH_DEF = 8;
    localparam int T_WIDTH_DEF  = 4;

    // Positions of the I/O opcode bits within the full IR.
    localparam int IR_INP    = 11;
    localparam int IR_OUT    = 10;
    localparam int IR_SKI    = 9;
    localparam int IR_SKO    = 8;
    localparam int IR_ION    = 7;
    localparam int IR_IOF    = 6;
    localparam int IR_IO_LSB = 6;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;

    typedef struct packed {
        logic inp;
        logic out;
        logic ski;
        logic sko;
        logic ion;
        logic iof;
    } io_op_t;

    // Decode IR[11:6] into one-hot-ish op flags.
    // Several bits may be set together; each acts independently.
    function automatic io_op_t decode_io(input logic [5:0] ir,
                                         input logic       en);
        io_op_t op;
        op.inp = en & ir[IR_INP - IR_IO_LSB];
        op.out = en & ir[IR_OUT - IR_IO_LSB];
        op.ski = en & ir[IR_SKI - IR_IO_LSB];
        op.sko = en & ir[IR_SKO - IR_IO_LSB];
        op.ion = en & ir[IR_ION - IR_IO_LSB];
        op.iof = en & ir[IR_IOF - IR_IO_LSB];
        return op;
    endfunction

endpackage

// File: rtl/bc_int_ctrl_if.sv
// Character-device handshake bundle for bc_int_ctrl.
// master: device side (drives in_valid/in_data/out_ack).
// slave : controller side (drives in_ready/out_valid/out_data).
interface bc_int_ctrl_if
    import bc_pkg::*;
#(
    parameter int IO_WIDTH = IO_WIDTH_DEF
) ();

    logic                in_valid;
    logic [IO_WIDTH-1:0] in_data;
    logic                in_ready;
    logic                out_valid;
    logic [IO_WIDTH-1:0] out_data;
    logic                out_ack;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ack
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ack
    );

endinterface

// File: rtl/bc_int_ctrl.sv
// Basic Computer interrupt / I/O controller: IEN, R, FGI, FGO, INPR, OUTR,
// the six I/O instructions and the RT0-RT2 interrupt-cycle strobes.
// Ports: clk, rst_n (sync, active low); t_state, io_exec, ir_io, ac_lo
// from CONTROLLER/DATA_PATH; io (device handshakes, slave modport);
// inpr, ac_ld_inpr, pc_skip, int_cycle, ien, fgi, fgo, int_* strobes.
module bc_int_ctrl
    import bc_pkg::*;
#(
    parameter int IO_WIDTH = IO_WIDTH_DEF,
    parameter int T_WIDTH  = T_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [T_WIDTH-1:0]  t_state,
    input  logic                io_exec,
    input  logic [5:0]          ir_io,
    input  logic [IO_WIDTH-1:0] ac_lo,
    bc_int_ctrl_if.slave        io,
    output logic [IO_WIDTH-1:0] inpr,
    output logic                ac_ld_inpr,
    output logic                pc_skip,
    output logic                int_cycle,
    output logic                ien,
    output logic                fgi,
    output logic                fgo,
    output logic                int_ar_clr,
    output logic                int_tr_ld_pc,
    output logic                int_mem_wr_tr,
    output logic                int_pc_clr,
    output logic                int_pc_inc,
    output logic                int_sc_clr
);

    logic                r_q, r_d;
    logic                ien_q, ien_d;
    logic                fgi_q, fgi_d;
    logic                fgo_q, fgo_d;
    logic [IO_WIDTH-1:0] inpr_q, inpr_d;
    logic [IO_WIDTH-1:0] outr_q, outr_d;

    io_op_t op;
    logic   in_acc;
    logic   out_acc;
    logic   rt0, rt1, rt2;
    logic   int_req;

    assign op = decode_io(ir_io, io_exec);

    assign in_acc  = io.in_valid & ~fgi_q;
    assign out_acc = io.out_ack & ~fgo_q;

    assign rt0 = r_q & (t_state == T_WIDTH'(T0));
    assign rt1 = r_q & (t_state == T_WIDTH'(T1));
    assign rt2 = r_q & (t_state == T_WIDTH'(T2));

    // Request only outside T0-T2 so a pending fetch is never split;
    // uses the registered IEN, so an ION in the same cycle is too late.
    assign int_req = (t_state >= T_WIDTH'(T3)) & ien_q & (fgi_q | fgo_q);

    always_comb begin
        r_d    = r_q;
        ien_d  = ien_q;
        fgi_d  = fgi_q;
        fgo_d  = fgo_q;
        inpr_d = inpr_q;
        outr_d = outr_q;

        if (int_req) r_d = 1'b1;
        if (rt2)     r_d = 1'b0;

        // IOF after ION so both together leave IEN clear; RT2 overrides all.
        if (op.ion) ien_d = 1'b1;
        if (op.iof) ien_d = 1'b0;
        if (rt2)    ien_d = 1'b0;

        // Device set beats INP clear: fresh data must not be lost.
        if (op.inp) fgi_d = 1'b0;
        if (in_acc) begin
            fgi_d  = 1'b1;
            inpr_d = io.in_data;
        end

        // OUT clear beats device ack: the new character is still pending.
        if (out_acc) fgo_d = 1'b1;
        if (op.out) begin
            fgo_d  = 1'b0;
            outr_d = ac_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= 1'b0;
            ien_q  <= 1'b0;
            fgi_q  <= 1'b0;
            fgo_q  <= 1'b1;
            inpr_q <= '0;
            outr_q <= '0;
        end else begin
            r_q    <= r_d;
            ien_q  <= ien_d;
            fgi_q  <= fgi_d;
            fgo_q  <= fgo_d;
            inpr_q <= inpr_d;
            outr_q <= outr_d;
        end
    end

    assign io.in_ready  = ~fgi_q;
    assign io.out_valid = ~fgo_q;
    assign io.out_data  = outr_q;

    assign inpr      = inpr_q;
    assign int_cycle = r_q;
    assign ien       = ien_q;
    assign fgi       = fgi_q;
    assign fgo       = fgo_q;

    // Strobes are muted during reset so no datapath write escapes.
    assign ac_ld_inpr    = rst_n & op.inp;
    assign pc_skip       = rst_n & ((op.ski & fgi_q) | (op.sko & fgo_q));
    assign int_ar_clr    = rst_n & rt0;
    assign int_tr_ld_pc  = rst_n & rt0;
    assign int_mem_wr_tr = rst_n & rt1;
    assign int_pc_clr    = rst_n & rt1;
    assign int_pc_inc    = rst_n & rt2;
    assign int_sc_clr    = rst_n & rt2;

endmodule

// File: tb/tb_bc_int_ctrl.sv
// Self-checking bench for bc_int_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a flag-level model.
module tb_bc_int_ctrl;
    import bc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] t_state;
    logic       io_exec;
    logic [5:0] ir_io;
    logic [7:0] ac_lo;

    logic [7:0] inpr;
    logic ac_ld_inpr, pc_skip, int_cycle, ien, fgi, fgo;
    logic int_ar_clr, int_tr_ld_pc, int_mem_wr_tr;
    logic int_pc_clr, int_pc_inc, int_sc_clr;

    bc_int_ctrl_if #(.IO_WIDTH(8)) io ();

    bc_int_ctrl #(.IO_WIDTH(8), .T_WIDTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .t_state       (t_state),
        .io_exec       (io_exec),
        .ir_io         (ir_io),
        .ac_lo         (ac_lo),
        .io            (io.slave),
        .inpr          (inpr),
        .ac_ld_inpr    (ac_ld_inpr),
        .pc_skip       (pc_skip),
        .int_cycle     (int_cycle),
        .ien           (ien),
        .fgi           (fgi),
        .fgo           (fgo),
        .int_ar_clr    (int_ar_clr),
        .int_tr_ld_pc  (int_tr_ld_pc),
        .int_mem_wr_tr (int_mem_wr_tr),
        .int_pc_clr    (int_pc_clr),
        .int_pc_inc    (int_pc_inc),
        .int_sc_clr    (int_sc_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Flag-level model of the architectural state.
    bit       m_r = 0, m_ien = 0, m_fgi = 0, m_fgo = 1;
    bit [7:0] m_inpr = 0, m_outr = 0;
    bit       n_r, n_ien, n_fgi, n_fgo;
    bit [7:0] n_inpr, n_outr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output, then the model's next state.
    always @(negedge clk) begin
        logic [29:0] act_v, exp_v;
        bit live, inp, outi, ski, sko, ion, iof;
        bit [5:0] rt;
        if (chk_en) begin
            live = (rst_n === 1'b1);
            inp  = io_exec && ir_io[5];
            outi = io_exec && ir_io[4];
            ski  = io_exec && ir_io[3];
            sko  = io_exec && ir_io[2];
            ion  = io_exec && ir_io[1];
            iof  = io_exec && ir_io[0];
            rt = 6'b0;
            if (live && m_r && t_state == 4'd0) rt = 6'b110000;
            if (live && m_r && t_state == 4'd1) rt = 6'b001100;
            if (live && m_r && t_state == 4'd2) rt = 6'b000011;
            exp_v = {m_r, m_ien, m_fgi, m_fgo, !m_fgi, !m_fgo, m_outr,
                     m_inpr, live && inp,
                     live && ((ski && m_fgi) || (sko && m_fgo)), rt};
            act_v = {int_cycle, ien, fgi, fgo, io.in_ready, io.out_valid,
                     io.out_data, inpr, ac_ld_inpr, pc_skip, int_ar_clr,
                     int_tr_ld_pc, int_mem_wr_tr, int_pc_clr, int_pc_inc,
                     int_sc_clr};
            chk("cycle_outputs", 32'(act_v), 32'(exp_v));

            if (!live) begin
                n_r = 0; n_ien = 0; n_fgi = 0; n_fgo = 1;
                n_inpr = 0; n_outr = 0;
            end else begin
                n_inpr = m_inpr;
                n_outr = m_outr;
                n_fgi  = inp ? 1'b0 : m_fgi;
                if (io.in_valid && !m_fgi) begin
                    n_fgi  = 1'b1;
                    n_inpr = io.in_data;
                end
                n_fgo = (io.out_ack && !m_fgo) ? 1'b1 : m_fgo;
                if (outi) begin
                    n_fgo  = 1'b0;
                    n_outr = ac_lo;
                end
                if (m_r && t_state == 4'd2) begin
                    n_r   = 0;
                    n_ien = 0;
                end else begin
                    n_ien = iof ? 1'b0 : (ion ? 1'b1 : m_ien);
                    n_r   = m_r || (t_state > 4'd2 && m_ien &&
                                    (m_fgi || m_fgo));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            m_r = n_r; m_ien = n_ien; m_fgi = n_fgi; m_fgo = n_fgo;
            m_inpr = n_inpr; m_outr = n_outr;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        io_exec     = 0;
        ir_io       = 0;
        io.in_valid = 0;
        io.out_ack  = 0;
    endtask

    initial begin
        rst_n = 0; t_state = 0; ac_lo = 0; io.in_data = 0;
        idle();
        tick();
        tick();
        chk_en = 1'b1;
        rst_n  = 1;
        #1;
        chk("reset_flags", {int_cycle, ien, fgi, fgo}, 4'b0001);
        chk("reset_hs", {io.out_valid, io.in_ready}, 2'b01);

        io.in_valid = 1; io.in_data = 8'h41;
        tick();
        idle();
        #1;
        chk("in_capture", {fgi, io.in_ready, inpr}, {2'b10, 8'h41});

        io_exec = 1; ir_io = 6'b100000;
        #1;
        chk("inp_ld", ac_ld_inpr, 1);
        tick();
        idle();
        #1;
        chk("inp_clr_fgi", fgi, 0);

        ac_lo = 8'h5A; io_exec = 1; ir_io = 6'b010000;
        tick();
        idle();
        #1;
        chk("out_data", {io.out_valid, io.out_data}, {1'b1, 8'h5A});

        io_exec = 1; ir_io = 6'b000100;
        #1;
        chk("sko_fgo0", pc_skip, 0);
        tick();
        idle();

        io.out_ack = 1;
        tick();
        idle();
        #1;
        chk("out_ack", {fgo, io.out_valid}, 2'b10);

        io.in_valid = 1; io.in_data = 8'hC3;
        tick();
        idle();
        io_exec = 1; ir_io = 6'b001000;
        #1;
        chk("ski_fgi1", pc_skip, 1);
        tick();
        idle();

        ac_lo = 8'h33; io_exec = 1; ir_io = 6'b110000;
        tick();
        idle();
        #1;
        chk("inp_out_both", {fgi, fgo, io.out_data}, {2'b00, 8'h33});

        io_exec = 1; ir_io = 6'b000011;
        tick();
        idle();
        #1;
        chk("ion_iof", ien, 0);

        io_exec = 1; ir_io = 6'b000010;
        tick();
        idle();
        t_state = 4'd5;
        io.in_valid = 1; io.in_data = 8'h77;
        tick();
        idle();
        #1;
        chk("fgi_rise", {ien, fgi, int_cycle}, 3'b110);
        tick();
        chk("r_set", int_cycle, 1);
        t_state = 4'd0;
        #1;
        chk("rt0", {int_ar_clr, int_tr_ld_pc, int_mem_wr_tr, int_pc_inc},
            4'b1100);
        tick();
        t_state = 4'd1;
        #1;
        chk("rt1", {int_ar_clr, int_mem_wr_tr, int_pc_clr, int_sc_clr},
            4'b0110);
        tick();
        t_state = 4'd2;
        #1;
        chk("rt2", {int_mem_wr_tr, int_pc_inc, int_sc_clr}, 3'b011);
        tick();
        t_state = 4'd0;
        #1;
        chk("after_rt2", {int_cycle, ien, int_ar_clr}, 3'b000);

        io_exec = 1; ir_io = 6'b000010;
        tick();
        idle();
        t_state = 4'd6;
        tick();
        chk("r_set2", int_cycle, 1);
        t_state = 4'd0;
        tick();
        t_state = 4'd1;
        rst_n = 0;
        #1;
        chk("rst_rt1", {int_mem_wr_tr, int_pc_clr}, 2'b00);
        tick();
        rst_n = 1;
        #1;
        chk("rst_after", {int_cycle, ien, fgi, fgo}, 4'b0001);

        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            t_state     = 4'($urandom_range(0, 15));
            io_exec     = ($urandom_range(0, 3) == 0);
            ir_io       = 6'($urandom);
            ac_lo       = 8'($urandom);
            io.in_valid = ($urandom_range(0, 3) == 0);
            io.in_data  = 8'($urandom);
            io.out_ack  = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
